csa_stream_accumulator: RTL and testbench



---
 rtl/csa_stream_accumulator_if.sv | 32 +++
 rtl/csa_stream_accumulator.sv | 134 +++++++++++++
 tb/tb_csa_stream_accumulator.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_stream_accumulator_if.sv
// Operand/result stream bundle for csa_stream_accumulator.
interface csa_stream_accumulator_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GUARD = 4,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned ACC_W = WIDTH + GUARD;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  // Operand source and result consumer side
  modport master (
    output in_valid, in_a, in_b, in_c, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_count
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_a, in_b, in_c, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_count
  );
endinterface

// File: rtl/csa_stream_accumulator.sv
// Carry-save frame accumulator: three operands per beat folded into a
// sum/carry pair with no carry propagation in the loop; one ripple resolve
// per frame produces the total, exact overflow flag and beat count.
module csa_stream_accumulator #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GUARD = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  csa_stream_accumulator_if.slave bus
);
  localparam int unsigned ACC_W = WIDTH + GUARD;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [ACC_W-1:0] acc_s;
  logic [ACC_W-1:0] acc_c;
  logic             ovf_acc;
  logic [CNT_W-1:0] cnt_acc;

  logic             accept_c;
  logic             resolve_c;

  logic [ACC_W-1:0] ext_a, ext_b, ext_c;
  logic [ACC_W-1:0] s1, c1, c1_sh;
  logic [ACC_W-1:0] s2, c2, c2_sh;
  logic [ACC_W-1:0] s3, c3, c3_sh;
  logic             drop_c;

  logic [ACC_W-1:0] cpa_sum;
  logic             cpa_carry;

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    resolve_c = 1'b0;
    case (state)
      ACCUM: begin
        accept_c = bus.in_valid;
        if (bus.in_valid && bus.in_last) begin
          state_nxt = RESOLVE;
        end
      end
      RESOLVE: begin
        resolve_c = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // State register; handshake flags registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ACCUM;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.in_ready  <= (state_nxt == ACCUM);
      bus.out_valid <= (state_nxt == HOLD);
    end
  end

  // 3:2 on the operands, then a 4:2 (two 3:2 levels) into the accumulator.
  // Every carry shifted past the MSB is worth exactly 2^ACC_W.
  always_comb begin
    ext_a  = ACC_W'(bus.in_a);
    ext_b  = ACC_W'(bus.in_b);
    ext_c  = ACC_W'(bus.in_c);
    s1     = ext_a ^ ext_b ^ ext_c;
    c1     = (ext_a & ext_b) | (ext_a & ext_c) | (ext_b & ext_c);
    c1_sh  = c1 << 1;
    s2     = s1 ^ c1_sh ^ acc_s;
    c2     = (s1 & c1_sh) | (s1 & acc_s) | (c1_sh & acc_s);
    c2_sh  = c2 << 1;
    s3     = s2 ^ c2_sh ^ acc_c;
    c3     = (s2 & c2_sh) | (s2 & acc_c) | (c2_sh & acc_c);
    c3_sh  = c3 << 1;
    drop_c = c1[ACC_W-1] | c2[ACC_W-1] | c3[ACC_W-1];
  end

  // Ripple-carry resolve of the carry-save pair
  always_comb begin
    cpa_sum   = '0;
    cpa_carry = 1'b0;
    for (int i = 0; i < int'(ACC_W); i++) begin
      cpa_sum[i] = acc_s[i] ^ acc_c[i] ^ cpa_carry;
      cpa_carry  = (acc_s[i] & acc_c[i]) | (cpa_carry & (acc_s[i] ^ acc_c[i]));
    end
  end

  // Accumulate accepted beats; on resolve, publish the result and clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_s         <= '0;
      acc_c         <= '0;
      ovf_acc       <= 1'b0;
      cnt_acc       <= '0;
      bus.out_sum   <= '0;
      bus.out_ovf   <= 1'b0;
      bus.out_count <= '0;
    end else if (accept_c) begin
      acc_s   <= s3;
      acc_c   <= c3_sh;
      ovf_acc <= ovf_acc | drop_c;
      if (!(&cnt_acc)) begin
        cnt_acc <= cnt_acc + CNT_W'(1);
      end
    end else if (resolve_c) begin
      bus.out_sum   <= cpa_sum;
      bus.out_ovf   <= ovf_acc | cpa_carry;
      bus.out_count <= cnt_acc;
      acc_s         <= '0;
      acc_c         <= '0;
      ovf_acc       <= 1'b0;
      cnt_acc       <= '0;
    end
  end
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Scoreboard bench for csa_stream_accumulator (CNT_W=8 main instance plus a
// CNT_W=2 instance for count saturation).
module tb_csa_stream_accumulator;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned GUARD = 4;
  localparam int unsigned CNT_W = 8;

  typedef struct {
    int unsigned sum;
    int unsigned ovf;
    int unsigned count;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int unsigned tot = 0;
  int unsigned cnt = 0;

  always #5 clk = ~clk;

  csa_stream_accumulator_if #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(CNT_W)) bus ();
  csa_stream_accumulator_if #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(2)) sbus ();

  csa_stream_accumulator #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  csa_stream_accumulator #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one beat after 'gap' idle cycles; model is updated on acceptance
  task automatic send_beat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input bit last, input int gap);
    int waited = 0;
    exp_t e;
    repeat (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_c     = c;
    bus.in_last  = last;
    while (!bus.in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    tot += 32'(a) + 32'(b) + 32'(c);
    cnt++;
    if (last) begin
      e.sum   = tot % 256;
      e.ovf   = (tot >= 256) ? 1 : 0;
      e.count = (cnt > 255) ? 255 : cnt;
      exp_q.push_back(e);
      tot = 0;
      cnt = 0;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic compare_pop();
    exp_t e;
    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("out_sum", 32'(bus.out_sum), e.sum);
    check("out_ovf", 32'(bus.out_ovf), e.ovf);
    check("out_count", 32'(bus.out_count), e.count);
  endtask

  // Wait for a result, stall 'delay' cycles, compare, then take it
  task automatic collect(input int delay);
    int waited = 0;
    while (!bus.out_valid && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.out_valid) begin
      check("out_timeout", 32'(bus.out_valid), 32'd1);
      return;
    end
    repeat (delay) @(negedge clk);
    compare_pop();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int sw;
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_c       = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    sbus.in_valid  = 1'b0;
    sbus.in_a      = '0;
    sbus.in_b      = '0;
    sbus.in_c      = '0;
    sbus.in_last   = 1'b0;
    sbus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    rst_n = 1'b1;

    // Single beat: accepted at edge k, valid after edge k+1
    send_beat(4'd15, 4'd15, 4'd15, 1'b1, 1);
    check("single_valid_k", 32'(bus.out_valid), 32'd0);
    check("single_ready_k", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("single_valid_k1", 32'(bus.out_valid), 32'd1);
    collect(0);

    // Four beats with idle gaps, then six beats crossing 2^ACC_W
    for (int i = 0; i < 4; i++) send_beat(4'd15, 4'd15, 4'd15, i == 3, 2);
    collect(0);
    for (int i = 0; i < 6; i++) send_beat(4'd15, 4'd15, 4'd15, i == 5, 0);
    collect(1);

    // Backpressure: result held, beats refused, in_ready one edge after take
    send_beat(4'd3, 4'd4, 4'd5, 1'b1, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 4'd15;
    bus.in_b     = 4'd15;
    bus.in_c     = 4'd15;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_sum", 32'(bus.out_sum), 32'd12);
    end
    compare_pop();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_after", 32'(bus.in_ready), 32'd1);
    check("bp_valid_after", 32'(bus.out_valid), 32'd0);
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    send_beat(4'd1, 4'd1, 4'd1, 1'b1, 0);
    collect(0);

    // Reset mid-frame discards the partial frame
    send_beat(4'd7, 4'd7, 4'd7, 1'b0, 0);
    send_beat(4'd7, 4'd7, 4'd7, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_out_sum", 32'(bus.out_sum), 32'd0);
    check("mrst_out_count", 32'(bus.out_count), 32'd0);
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    tot = 0;
    cnt = 0;
    #2;
    rst_n = 1'b1;
    send_beat(4'd1, 4'd2, 4'd3, 1'b1, 0);
    collect(0);

    // Count saturation on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("sat_in_ready", 32'(sbus.in_ready), 32'd1);
      sbus.in_valid = 1'b1;
      sbus.in_c     = 4'd1;
      sbus.in_last  = (i == 4);
    end
    @(negedge clk);
    sbus.in_valid = 1'b0;
    sbus.in_last  = 1'b0;
    sw = 0;
    while (!sbus.out_valid && sw < 50) begin
      @(negedge clk);
      sw++;
    end
    check("sat_out_valid", 32'(sbus.out_valid), 32'd1);
    check("sat_out_sum", 32'(sbus.out_sum), 32'd5);
    check("sat_out_count", 32'(sbus.out_count), 32'd3);
    check("sat_out_ovf", 32'(sbus.out_ovf), 32'd0);
    sbus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    sbus.out_ready = 1'b0;

    // Random frames with random input gaps and consumer stalls
    fork
      begin
        for (int f = 0; f < 20; f++) begin
          int nb;
          nb = int'($urandom_range(1, 40));
          for (int j = 0; j < nb; j++) begin
            send_beat(4'($urandom), 4'($urandom), 4'($urandom), j == nb - 1,
                      int'($urandom_range(0, 2)));
          end
        end
      end
      begin
        for (int f = 0; f < 20; f++) collect(int'($urandom_range(0, 4)));
      end
    join

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
